pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter REG_ADDR_W, default 5: register-specifier width.
REQ-002 Parameter ALUOP_W, default 4: ALUOp width.
REQ-003 Parameter FORWARD_EN, default 1: 1 = forwarding mode; 0 = stall-only RAW resolution.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 instruction  input  32  IF/ID instruction (ID stage).
REQ-007 alu_zero  input  1  EX-stage ALU zero flag.
REQ-008 ex_RegDst, ex_ALUSrc  output  1 each  EX-stage controls.
REQ-009 ex_ALUOp  output  ALUOP_W  EX-stage ALU operation.
REQ-010 mem_MemWrite  output  1  MEM-stage write enable.
REQ-011 wb_MemtoReg, wb_RegWrite  output  1 each  WB-stage controls.
REQ-012 id_Jump, id_Ext_op  output  1 each  ID-stage combinational controls.
REQ-013 wb_dst  output  REG_ADDR_W  WB write register.
REQ-014 pc_write, ifid_write, ifid_flush  output  1 each  PC / IF-ID register control.
REQ-015 pc_src  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-016 forward_a, forward_b  output  2  00 register file, 01 MEM/WB, 10 EX/MEM.
REQ-017 stall  output  1  hazard-stall status.

Function
REQ-018 Decode: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, ori 001101. Any other opcode decodes to all-zero controls (NOP).
REQ-019 ALUOp codes: FUNCT 0000 for R-type, ADD 0001 for lw/sw/addi, SUB 0010 for beq, OR 0011 for ori.
REQ-020 Ext_op = 1 for lw, sw, addi, beq; Ext_op = 0 otherwise.
REQ-021 Controls advance one stage per cycle through the ID/EX, EX/MEM and MEM/WB registers. An ID-decoded signal appears on its stage output 1 cycle (EX), 2 cycles (MEM) or 3 cycles (WB) later.
REQ-022 EX destination = RegDst ? rd : rt. The destination is pipelined to MEM and WB alongside RegWrite.
REQ-023 Register 0 is never a hazard or forwarding source.
REQ-024 Load-use hazard: when the EX stage is lw and its rt matches the ID rs, or matches the ID rt for R-type/sw/beq, the block asserts stall=1, pc_write=0 and ifid_write=0, and inserts a bubble (zero controls) into ID/EX for exactly 1 cycle.
REQ-025 When FORWARD_EN=1, forward_a = 10 if mem_RegWrite and mem_dst equals ex_rs; else 01 if wb_RegWrite and wb_dst equals ex_rs; else 00. EX/MEM has priority. forward_b applies the same rule against ex_rt.
REQ-026 When FORWARD_EN=0, forward_a and forward_b are 00 constantly. The block stalls while any ID source matches a RegWrite destination in EX or MEM. WB needs no stall because the register file writes before it reads.
REQ-027 Branch resolves in MEM: alu_zero is registered into EX/MEM, and pc_src = 01 when mem_Branch and mem_zero are both 1.
REQ-028 Taken branch: the block asserts ifid_flush and bubbles the ID/EX and EX/MEM inputs in the same cycle, squashing 3 instructions.
REQ-029 Jump in ID: pc_src = 10, ifid_flush = 1, and the j instruction proceeds as a NOP.
REQ-030 Priority: a taken branch wins over a jump, and a jump wins over a stall. When a flush and a stall coincide, pc_write = 1 and stall = 0.
REQ-031 A flushed or bubbled slot never asserts MemWrite or RegWrite.

Reset
REQ-032 While reset is asserted, all pipeline control registers and destinations clear to 0. At the first active clock edge after reset deasserts, the outputs are: stall=0, pc_write=1, ifid_write=1, ifid_flush=0, pc_src=00, forward_a=forward_b=00.
REQ-033 Reset asserted mid-operation clears all in-flight instructions on the next edge, with no partial writes.

Structure
REQ-034 A shared package pipeline_pkg holds the opcode constants, the ALUOp codes, the pc_src and forward encodings, and the control-bundle struct.
REQ-035 A single sub-module, main_decoder, holds the purely combinational opcode-to-bundle decode. Hazard, forwarding and the stage registers live in pipeline_controller.

Verification
REQ-036 Reset held 2 cycles, then NOPs -> every registered control output is 0, pc_write=1, stall=0.
REQ-037 lw $2 followed by add $3,$2,$4 -> stall=1 for exactly 1 cycle, then forward_a=01 when the add is in EX.
REQ-038 add $2 followed by sub $5,$2,$2, with FORWARD_EN=1 -> forward_a=forward_b=10 and no stall.
REQ-039 The same add/sub pair with FORWARD_EN=0 -> stall for 2 cycles, then forward_a=forward_b=00.
REQ-040 beq with alu_zero=1 -> when the beq is in MEM, pc_src=01 and ifid_flush=1, and the 3 younger slots produce no RegWrite or MemWrite.
REQ-041 j issued while a load-use stall is pending -> pc_src=10, pc_write=1, stall=0. Then opcode 111111 -> all controls 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline controller: opcodes, ALU operation codes,
// PC-select and forwarding encodings, and the decoded control bundle.
package pipeline_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;

  localparam logic [3:0] AluFunct = 4'b0000;
  localparam logic [3:0] AluAdd   = 4'b0001;
  localparam logic [3:0] AluSub   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;

  localparam logic [1:0] PcSeq    = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       mem_to_reg;
    logic       reg_write;
    logic       jump;
    logic       ext_op;
  } ctrl_t;

  localparam int unsigned CtrlW   = $bits(ctrl_t);
  localparam ctrl_t       CtrlNop = '0;

endpackage

// File: rtl/main_decoder.sv
// Purely combinational opcode-to-control-bundle decode; unknown opcodes give a NOP bundle.
module main_decoder
  import pipeline_pkg::*;
(
  input  logic [5:0]       opcode,
  output logic [CtrlW-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = CtrlNop;
    case (opcode)
      OpRtype: begin
        c.reg_dst   = 1'b1;
        c.alu_op    = AluFunct;
        c.reg_write = 1'b1;
      end
      OpLw: begin
        c.alu_src    = 1'b1;
        c.alu_op     = AluAdd;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.ext_op     = 1'b1;
      end
      OpSw: begin
        c.alu_src   = 1'b1;
        c.alu_op    = AluAdd;
        c.mem_write = 1'b1;
        c.ext_op    = 1'b1;
      end
      OpBeq: begin
        c.alu_op = AluSub;
        c.branch = 1'b1;
        c.ext_op = 1'b1;
      end
      OpJ: begin
        c.jump = 1'b1;
      end
      OpAddi: begin
        c.alu_src   = 1'b1;
        c.alu_op    = AluAdd;
        c.reg_write = 1'b1;
        c.ext_op    = 1'b1;
      end
      OpOri: begin
        c.alu_src   = 1'b1;
        c.alu_op    = AluOr;
        c.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline control: stage registers for the control bundle, hazard stall,
// operand forwarding, and branch/jump redirect with flush.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 4,
  parameter int unsigned FORWARD_EN = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic                  alu_zero,
  output logic                  ex_RegDst,
  output logic                  ex_ALUSrc,
  output logic [ALUOP_W-1:0]    ex_ALUOp,
  output logic                  mem_MemWrite,
  output logic                  wb_MemtoReg,
  output logic                  wb_RegWrite,
  output logic                  id_Jump,
  output logic                  id_Ext_op,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic [1:0]            pc_src,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall
);

  ctrl_t                 id_ctrl;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
  logic                  id_uses_rt;

  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  logic [REG_ADDR_W-1:0] ex_dst;

  logic                  mem_mem_write_q, mem_mem_write_d;
  logic                  mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic                  mem_branch_q, mem_branch_d;
  logic                  mem_zero_q, mem_zero_d;
  logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;

  logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;

  logic load_use, raw_ex, raw_mem, hazard;
  logic branch_taken, flush;
  logic unused_bits;

  main_decoder u_main_decoder (
    .opcode (instruction[31:26]),
    .ctrl   (id_ctrl)
  );

  assign id_rs = REG_ADDR_W'(instruction[25:21]);
  assign id_rt = REG_ADDR_W'(instruction[20:16]);
  assign id_rd = REG_ADDR_W'(instruction[15:11]);
  assign id_uses_rt = (instruction[31:26] == OpRtype) || (instruction[31:26] == OpSw) ||
                      (instruction[31:26] == OpBeq);

  assign ex_dst = ex_ctrl_q.reg_dst ? ex_rd_q : ex_rt_q;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic src_hit(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  always_comb begin
    load_use = src_hit(ex_ctrl_q.mem_read, ex_rt_q, id_rs) ||
               (id_uses_rt && src_hit(ex_ctrl_q.mem_read, ex_rt_q, id_rt));
    raw_ex   = src_hit(ex_ctrl_q.reg_write, ex_dst, id_rs) ||
               (id_uses_rt && src_hit(ex_ctrl_q.reg_write, ex_dst, id_rt));
    raw_mem  = src_hit(mem_reg_write_q, mem_dst_q, id_rs) ||
               (id_uses_rt && src_hit(mem_reg_write_q, mem_dst_q, id_rt));
    hazard   = (FORWARD_EN != 0) ? load_use : (raw_ex || raw_mem);
  end

  // A redirect squashes the stalled instruction, so it overrides the stall.
  assign branch_taken = mem_branch_q & mem_zero_q;
  assign flush        = branch_taken | id_ctrl.jump;
  assign stall        = hazard & ~flush;
  assign pc_write     = ~stall;
  assign ifid_write   = ~stall;
  assign ifid_flush   = flush;

  always_comb begin
    pc_src = PcSeq;
    if (branch_taken) begin
      pc_src = PcBranch;
    end else if (id_ctrl.jump) begin
      pc_src = PcJump;
    end
  end

  always_comb begin
    forward_a = FwdRf;
    forward_b = FwdRf;
    if (FORWARD_EN != 0) begin
      if (src_hit(mem_reg_write_q, mem_dst_q, ex_rs_q)) begin
        forward_a = FwdMem;
      end else if (src_hit(wb_reg_write_q, wb_dst_q, ex_rs_q)) begin
        forward_a = FwdWb;
      end
      if (src_hit(mem_reg_write_q, mem_dst_q, ex_rt_q)) begin
        forward_b = FwdMem;
      end else if (src_hit(wb_reg_write_q, wb_dst_q, ex_rt_q)) begin
        forward_b = FwdWb;
      end
    end
  end

  always_comb begin
    ex_ctrl_d = id_ctrl;
    ex_rs_d   = id_rs;
    ex_rt_d   = id_rt;
    ex_rd_d   = id_rd;
    if (stall || branch_taken) begin
      ex_ctrl_d = CtrlNop;
      ex_rs_d   = '0;
      ex_rt_d   = '0;
      ex_rd_d   = '0;
    end

    mem_mem_write_d  = ex_ctrl_q.mem_write;
    mem_mem_to_reg_d = ex_ctrl_q.mem_to_reg;
    mem_reg_write_d  = ex_ctrl_q.reg_write;
    mem_branch_d     = ex_ctrl_q.branch;
    mem_zero_d       = alu_zero;
    mem_dst_d        = ex_dst;
    if (branch_taken) begin
      mem_mem_write_d  = 1'b0;
      mem_mem_to_reg_d = 1'b0;
      mem_reg_write_d  = 1'b0;
      mem_branch_d     = 1'b0;
      mem_zero_d       = 1'b0;
      mem_dst_d        = '0;
    end

    wb_mem_to_reg_d = mem_mem_to_reg_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_dst_d        = mem_dst_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_ctrl_q        <= CtrlNop;
      ex_rs_q          <= '0;
      ex_rt_q          <= '0;
      ex_rd_q          <= '0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_branch_q     <= 1'b0;
      mem_zero_q       <= 1'b0;
      mem_dst_q        <= '0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_dst_q         <= '0;
    end else begin
      ex_ctrl_q        <= ex_ctrl_d;
      ex_rs_q          <= ex_rs_d;
      ex_rt_q          <= ex_rt_d;
      ex_rd_q          <= ex_rd_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_branch_q     <= mem_branch_d;
      mem_zero_q       <= mem_zero_d;
      mem_dst_q        <= mem_dst_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_dst_q         <= wb_dst_d;
    end
  end

  assign ex_RegDst    = ex_ctrl_q.reg_dst;
  assign ex_ALUSrc    = ex_ctrl_q.alu_src;
  assign ex_ALUOp     = ALUOP_W'(ex_ctrl_q.alu_op);
  assign mem_MemWrite = mem_mem_write_q;
  assign wb_MemtoReg  = wb_mem_to_reg_q;
  assign wb_RegWrite  = wb_reg_write_q;
  assign wb_dst       = wb_dst_q;
  assign id_Jump      = id_ctrl.jump;
  assign id_Ext_op    = id_ctrl.ext_op;

  assign unused_bits = ^{instruction[10:0], ex_ctrl_q.jump, ex_ctrl_q.ext_op};

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: one instance with forwarding, one stall-only,
// driven with the same ID-stage instruction stream and checked against hand-derived values.
module tb_pipeline_controller;

  localparam logic [31:0] NOP    = 32'hFC000000;  // undefined opcode 111111, zero fields
  localparam logic [31:0] UNDEF  = 32'hFFFFFFFF;
  localparam logic [31:0] ORI7   = 32'h34270005;  // ori  $7,$1,5
  localparam logic [31:0] SW21   = 32'hAC220000;  // sw   $2,0($1)
  localparam logic [31:0] SW52   = 32'hACA20000;  // sw   $2,0($5)
  localparam logic [31:0] ADD9   = 32'h00264820;  // add  $9,$1,$6
  localparam logic [31:0] ADDI8  = 32'h20280001;  // addi $8,$1,1
  localparam logic [31:0] ADDI25 = 32'h20A20001;  // addi $2,$5,1
  localparam logic [31:0] LW2    = 32'h8C220000;  // lw   $2,0($1)
  localparam logic [31:0] LW0    = 32'h8C200000;  // lw   $0,0($1)
  localparam logic [31:0] ADD3   = 32'h00441820;  // add  $3,$2,$4
  localparam logic [31:0] ADD300 = 32'h00001820;  // add  $3,$0,$0
  localparam logic [31:0] ADD2   = 32'h00261020;  // add  $2,$1,$6
  localparam logic [31:0] SUB5   = 32'h00422822;  // sub  $5,$2,$2
  localparam logic [31:0] BEQ    = 32'h10210004;  // beq  $1,$1,4
  localparam logic [31:0] J2     = 32'h08400010;  // j with target bits [25:21] = 2

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_zero;
  logic [31:0] instruction;

  logic       f_ex_RegDst, f_ex_ALUSrc, f_mem_MemWrite, f_wb_MemtoReg, f_wb_RegWrite;
  logic       f_id_Jump, f_id_Ext_op, f_pc_write, f_ifid_write, f_ifid_flush, f_stall;
  logic [3:0] f_ex_ALUOp;
  logic [4:0] f_wb_dst;
  logic [1:0] f_pc_src, f_forward_a, f_forward_b;

  logic       n_ex_RegDst, n_ex_ALUSrc, n_mem_MemWrite, n_wb_MemtoReg, n_wb_RegWrite;
  logic       n_id_Jump, n_id_Ext_op, n_pc_write, n_ifid_write, n_ifid_flush, n_stall;
  logic [3:0] n_ex_ALUOp;
  logic [4:0] n_wb_dst;
  logic [1:0] n_pc_src, n_forward_a, n_forward_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipeline_controller #(.REG_ADDR_W(5), .ALUOP_W(4), .FORWARD_EN(1)) dut_f (
    .clock(clock), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .ex_RegDst(f_ex_RegDst), .ex_ALUSrc(f_ex_ALUSrc), .ex_ALUOp(f_ex_ALUOp),
    .mem_MemWrite(f_mem_MemWrite), .wb_MemtoReg(f_wb_MemtoReg), .wb_RegWrite(f_wb_RegWrite),
    .id_Jump(f_id_Jump), .id_Ext_op(f_id_Ext_op), .wb_dst(f_wb_dst),
    .pc_write(f_pc_write), .ifid_write(f_ifid_write), .ifid_flush(f_ifid_flush),
    .pc_src(f_pc_src), .forward_a(f_forward_a), .forward_b(f_forward_b), .stall(f_stall)
  );

  pipeline_controller #(.REG_ADDR_W(5), .ALUOP_W(4), .FORWARD_EN(0)) dut_n (
    .clock(clock), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .ex_RegDst(n_ex_RegDst), .ex_ALUSrc(n_ex_ALUSrc), .ex_ALUOp(n_ex_ALUOp),
    .mem_MemWrite(n_mem_MemWrite), .wb_MemtoReg(n_wb_MemtoReg), .wb_RegWrite(n_wb_RegWrite),
    .id_Jump(n_id_Jump), .id_Ext_op(n_id_Ext_op), .wb_dst(n_wb_dst),
    .pc_write(n_pc_write), .ifid_write(n_ifid_write), .ifid_flush(n_ifid_flush),
    .pc_src(n_pc_src), .forward_a(n_forward_a), .forward_b(n_forward_b), .stall(n_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: present a new ID instruction mid-cycle and let it settle.
  task automatic step(input logic [31:0] ins, input logic z);
    @(negedge clock);
    instruction = ins;
    alu_zero    = z;
    #1;
  endtask

  // {stall, pc_write, ifid_write, ifid_flush, pc_src, forward_a, forward_b,
  //  ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemWrite, wb_MemtoReg, wb_RegWrite, wb_dst}
  function automatic logic [31:0] f_vec();
    return {8'h00, f_stall, f_pc_write, f_ifid_write, f_ifid_flush, f_pc_src, f_forward_a,
            f_forward_b, f_ex_RegDst, f_ex_ALUSrc, f_ex_ALUOp, f_mem_MemWrite, f_wb_MemtoReg,
            f_wb_RegWrite, f_wb_dst};
  endfunction

  initial begin
    reset       = 1'b1;
    instruction = NOP;
    alu_zero    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_state_f", f_vec(), 32'h00600000);
    chk("reset_jump_ext", {f_id_Jump, f_id_Ext_op}, 0);
    chk("reset_state_n_stall", {n_stall, n_pc_write}, 1);
    step(NOP, 0);
    chk("first_edge_f", f_vec(), 32'h00600000);
    step(NOP, 0);
    chk("idle_nops_f", f_vec(), 32'h00600000);

    // Decode and stage timing
    step(ORI7, 0);
    chk("ori_ext", f_id_Ext_op, 0);
    step(SW21, 0);
    chk("ori_ex_aluop", f_ex_ALUOp, 4'h3);
    chk("ori_ex_alusrc", f_ex_ALUSrc, 1);
    chk("ori_ex_regdst", f_ex_RegDst, 0);
    chk("sw_ext", f_id_Ext_op, 1);
    step(ADD9, 0);
    chk("sw_ex_aluop", f_ex_ALUOp, 4'h1);
    chk("ori_mem_memwrite", f_mem_MemWrite, 0);
    step(ADDI8, 0);
    chk("add_ex_regdst", f_ex_RegDst, 1);
    chk("add_ex_aluop", f_ex_ALUOp, 4'h0);
    chk("add_ex_alusrc", f_ex_ALUSrc, 0);
    chk("sw_mem_memwrite", f_mem_MemWrite, 1);
    chk("ori_wb_regwrite", f_wb_RegWrite, 1);
    chk("ori_wb_dst", f_wb_dst, 7);
    chk("ori_wb_memtoreg", f_wb_MemtoReg, 0);
    chk("addi_ext", f_id_Ext_op, 1);
    step(NOP, 0);
    chk("addi_ex_ctl", {f_ex_RegDst, f_ex_ALUSrc, f_ex_ALUOp}, 6'b01_0001);
    chk("add_mem_memwrite", f_mem_MemWrite, 0);
    chk("sw_wb_regwrite", f_wb_RegWrite, 0);
    step(NOP, 0);
    chk("add_wb", {f_wb_RegWrite, f_wb_dst}, {1'b1, 5'd9});
    step(NOP, 0);
    chk("addi_wb", {f_wb_RegWrite, f_wb_dst}, {1'b1, 5'd8});
    step(NOP, 0);

    // Load-use on rs: one bubble, then forwarded from MEM/WB
    step(LW2, 0);
    chk("lu_before_stall", f_stall, 0);
    step(ADD3, 0);
    chk("lu_stall", {f_stall, f_pc_write, f_ifid_write}, 3'b100);
    chk("lw_ex_ctl", {f_ex_ALUSrc, f_ex_ALUOp}, 5'b1_0001);
    step(ADD3, 0);
    chk("lu_release", {f_stall, f_pc_write, f_ifid_write}, 3'b011);
    chk("lu_bubble_ex", {f_ex_RegDst, f_ex_ALUSrc, f_ex_ALUOp}, 0);
    chk("lu_lw_mem_memwrite", f_mem_MemWrite, 0);
    step(NOP, 0);
    chk("lu_fwd_a", f_forward_a, 2'b01);
    chk("lu_fwd_b", f_forward_b, 2'b00);
    chk("lw_wb", {f_wb_MemtoReg, f_wb_RegWrite, f_wb_dst}, {2'b11, 5'd2});
    chk("lu_add_ex_regdst", f_ex_RegDst, 1);

    // Load-use via rt for sw, none for addi rt, none on register 0
    step(LW2, 0);
    step(SW52, 0);
    chk("lu_sw_rt_stall", f_stall, 1);
    step(SW52, 0);
    chk("lu_sw_release", f_stall, 0);
    step(LW2, 0);
    step(ADDI25, 0);
    chk("lu_addi_rt_nostall", f_stall, 0);
    step(LW0, 0);
    step(ADD300, 0);
    chk("lu_r0_nostall", f_stall, 0);
    step(NOP, 0);
    chk("fwd_r0", {f_forward_a, f_forward_b}, 0);

    // Forwarding from EX/MEM, from MEM/WB, and EX/MEM priority
    step(NOP, 0);
    step(NOP, 0);
    step(ADD2, 0);
    step(SUB5, 0);
    chk("fwd_mem_nostall", f_stall, 0);
    step(NOP, 0);
    chk("fwd_mem_ab", {f_forward_a, f_forward_b}, 4'b1010);
    step(ADD2, 0);
    step(NOP, 0);
    step(SUB5, 0);
    step(NOP, 0);
    chk("fwd_wb_ab", {f_forward_a, f_forward_b}, 4'b0101);
    step(ADD2, 0);
    step(ADD2, 0);
    step(SUB5, 0);
    step(NOP, 0);
    chk("fwd_priority_ab", {f_forward_a, f_forward_b}, 4'b1010);

    // Taken branch squashes three younger slots
    step(NOP, 0);
    step(NOP, 0);
    step(BEQ, 0);
    chk("beq_ext", f_id_Ext_op, 1);
    step(ADD9, 1);
    chk("beq_ex_aluop", f_ex_ALUOp, 4'h2);
    step(SW21, 0);
    chk("br_redirect", {f_pc_src, f_ifid_flush, f_pc_write, f_stall}, 5'b01_1_1_0);
    step(NOP, 0);
    chk("br_after", {f_pc_src, f_ifid_flush}, 0);
    chk("br_bubble_ex", {f_ex_RegDst, f_ex_ALUSrc, f_ex_ALUOp}, 0);
    chk("br_bubble_mem", f_mem_MemWrite, 0);
    step(NOP, 0);
    chk("br_squash_mem", f_mem_MemWrite, 0);
    chk("br_squash_wb", f_wb_RegWrite, 0);
    step(NOP, 0);
    chk("br_squash_wb2", f_wb_RegWrite, 0);
    step(BEQ, 0);
    step(NOP, 0);
    step(NOP, 0);
    chk("br_not_taken", {f_pc_src, f_ifid_flush}, 0);

    // Jump overrides a pending load-use stall; undefined opcode is a NOP
    step(LW2, 0);
    step(J2, 0);
    chk("j_over_stall", {f_pc_src, f_pc_write, f_ifid_write, f_stall}, 5'b10_1_1_0);
    chk("j_flush_jump", {f_ifid_flush, f_id_Jump}, 2'b11);
    step(UNDEF, 0);
    chk("undef_id", {f_id_Jump, f_id_Ext_op}, 0);
    chk("j_ex_nop", {f_ex_RegDst, f_ex_ALUSrc, f_ex_ALUOp}, 0);
    step(NOP, 0);
    chk("undef_ex", {f_ex_RegDst, f_ex_ALUSrc, f_ex_ALUOp}, 0);
    step(NOP, 0);
    chk("undef_mem", f_mem_MemWrite, 0);
    chk("j_wb", f_wb_RegWrite, 0);
    step(NOP, 0);
    chk("undef_wb", {f_wb_MemtoReg, f_wb_RegWrite}, 0);

    // Reset mid-operation discards in-flight add and sw
    step(ADD9, 0);
    step(SW21, 0);
    @(negedge clock);
    reset       = 1'b1;
    instruction = NOP;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_f", f_vec(), 32'h00600000);
    chk("midrst_n", {n_mem_MemWrite, n_wb_RegWrite, n_wb_dst}, 0);
    step(NOP, 0);
    chk("midrst_wb", {f_wb_RegWrite, f_wb_dst}, 0);

    // Stall-only mode: add/sub dependency stalls two cycles, no forwarding
    step(ADD2, 0);
    chk("nf_no_stall", n_stall, 0);
    step(SUB5, 0);
    chk("nf_stall_ex", {n_stall, n_pc_write, n_ifid_write}, 3'b100);
    step(SUB5, 0);
    chk("nf_stall_mem", {n_stall, n_pc_write, n_ifid_write}, 3'b100);
    step(SUB5, 0);
    chk("nf_release", {n_stall, n_pc_write, n_ifid_write}, 3'b011);
    step(NOP, 0);
    chk("nf_fwd", {n_forward_a, n_forward_b}, 0);
    chk("nf_sub_ex", n_ex_RegDst, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
